// File: rtl/lint_apb_bridge_if.sv
// rtl/lint_apb_bridge_if.sv - LINT request/response and APB3 bus interfaces for lint_apb_bridge
interface lint_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 5
);
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [ADDR_WIDTH-1:0] data_add_i;
    logic                  data_wen_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [3:0]            data_be_i;
    logic [ID_WIDTH-1:0]   data_id_i;
    logic                  data_r_valid_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic                  data_r_opc_o;
    logic [ID_WIDTH-1:0]   data_r_id_o;

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_id_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_id_o
    );

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_id_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_id_o
    );
endinterface

interface apb_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic                  pwrite_o;
    logic                  psel_o;
    logic                  penable_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/lint_apb_bridge.sv
// rtl/lint_apb_bridge.sv - single-outstanding LINT to APB3 bridge with ACCESS-phase watchdog
module lint_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int ID_WIDTH       = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    lint_bus_if.slave  lint,
    apb_bus_if.master  apb
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    localparam logic [7:0]                LP_TIMEOUT    = 8'(TIMEOUT_CYCLES);
    localparam bit                        LP_WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [APB_DATA_WIDTH-1:0] LP_ABORT_DATA = APB_DATA_WIDTH'(32'hDEAD_0B0B);

    state_t                    r_state;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;
    logic [7:0]                r_cnt;
    logic                      r_rvalid;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_opc;
    logic [ID_WIDTH-1:0]       r_id;

    logic w_gnt;
    logic w_partial;

    assign w_gnt     = lint.data_req_i && (r_state == ST_IDLE);
    assign w_partial = !lint.data_wen_i && (lint.data_be_i != 4'hF);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= 8'd0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_opc     <= 1'b0;
            r_id      <= '0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_id <= lint.data_id_i;
                        // Sub-word writes are not representable on APB3; refuse them locally.
                        if (w_partial) begin
                            r_rdata  <= '0;
                            r_opc    <= 1'b1;
                            r_rvalid <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_paddr  <= lint.data_add_i;
                            r_pwdata <= lint.data_wdata_i;
                            r_pwrite <= ~lint.data_wen_i;
                            r_psel   <= 1'b1;
                            r_state  <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= 8'd0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Completion takes priority over a watchdog hit in the same cycle.
                    if (apb.pready_i) begin
                        r_rdata   <= r_pwrite ? '0 : apb.prdata_i;
                        r_opc     <= apb.pslverr_i;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= ST_RESP;
                    end else if (LP_WDOG_EN && (r_cnt == LP_TIMEOUT)) begin
                        r_rdata   <= LP_ABORT_DATA;
                        r_opc     <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign lint.data_gnt_o     = w_gnt;
    assign lint.data_r_valid_o = r_rvalid;
    assign lint.data_r_rdata_o = r_rdata;
    assign lint.data_r_opc_o   = r_opc;
    assign lint.data_r_id_o    = r_id;

    assign apb.paddr_o   = r_paddr;
    assign apb.pwdata_o  = r_pwdata;
    assign apb.pwrite_o  = r_pwrite;
    assign apb.psel_o    = r_psel;
    assign apb.penable_o = r_penable;
endmodule

// File: tb/tb_lint_apb_bridge.sv
// tb/tb_lint_apb_bridge.sv - directed self-checking bench for lint_apb_bridge
module tb_lint_apb_bridge;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lint_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(5)) lint ();
    apb_bus_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32))               apb ();

    lint_apb_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .ID_WIDTH(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .lint(lint),
        .apb(apb)
    );

    // Results of the most recent xfer() call.
    logic        x_gnt0;
    int          x_rv;
    logic [31:0] x_rdata;
    logic        x_opc;
    logic [4:0]  x_id;
    int          x_psel;
    int          x_acc;
    bit          x_stable;
    logic        x_after;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and plays the APB slave: pready rises on access cycle waits+1 unless hang.
    task automatic xfer(input logic [31:0] add, input logic wen, input logic [31:0] wd,
                        input logic [3:0] be, input logic [4:0] id, input int waits,
                        input bit hang, input logic [31:0] rd, input logic err);
        lint.data_req_i   = 1'b1;
        lint.data_add_i   = add;
        lint.data_wen_i   = wen;
        lint.data_wdata_i = wd;
        lint.data_be_i    = be;
        lint.data_id_i    = id;
        apb.pready_i      = 1'b0;
        apb.prdata_i      = rd;
        apb.pslverr_i     = err;
        #1;
        x_gnt0   = lint.data_gnt_o;
        x_rv     = -1;
        x_psel   = 0;
        x_acc    = 0;
        x_stable = 1'b1;
        x_rdata  = 'x;
        x_opc    = 1'bx;
        x_id     = 'x;
        for (int c = 1; c <= 40; c++) begin
            step();
            lint.data_req_i = 1'b0;
            if (apb.psel_o === 1'b1) begin
                x_psel++;
                if (apb.paddr_o !== add || apb.pwrite_o !== ~wen || (!wen && apb.pwdata_o !== wd))
                    x_stable = 1'b0;
            end
            if (apb.psel_o === 1'b1 && apb.penable_o === 1'b1) begin
                x_acc++;
                apb.pready_i = !hang && (x_acc == waits + 1);
            end else begin
                apb.pready_i = 1'b0;
            end
            if (lint.data_r_valid_o === 1'b1) begin
                x_rv    = c;
                x_rdata = lint.data_r_rdata_o;
                x_opc   = lint.data_r_opc_o;
                x_id    = lint.data_r_id_o;
                break;
            end
        end
        step();
        x_after = lint.data_r_valid_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lint.data_req_i = 1'b0; lint.data_add_i = '0; lint.data_wen_i = 1'b1;
        lint.data_wdata_i = '0; lint.data_be_i = 4'hF; lint.data_id_i = '0;
        apb.prdata_i = '0; apb.pready_i = 1'b0; apb.pslverr_i = 1'b0;
        #12;
        checks++;
        if ({apb.psel_o, apb.penable_o, apb.pwrite_o} !== 3'b000) begin
            failures++; $display("FAIL reset_apb_ctrl got=%b exp=000", {apb.psel_o, apb.penable_o, apb.pwrite_o});
        end
        checks++;
        if ({apb.paddr_o, apb.pwdata_o} !== 64'h0) begin
            failures++; $display("FAIL reset_apb_data got=%h exp=0", {apb.paddr_o, apb.pwdata_o});
        end
        checks++;
        if ({lint.data_r_valid_o, lint.data_r_rdata_o, lint.data_r_opc_o, lint.data_r_id_o} !== 39'h0) begin
            failures++; $display("FAIL reset_resp got=%h exp=0",
                {lint.data_r_valid_o, lint.data_r_rdata_o, lint.data_r_opc_o, lint.data_r_id_o});
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_zero_wait();
        xfer(32'h1A10_4000, 1'b1, 32'h0, 4'hF, 5'd3, 0, 1'b0, 32'h1234_5678, 1'b0);
        checks++; if (x_gnt0 !== 1'b1) begin failures++; $display("FAIL rd0_gnt got=%b exp=1", x_gnt0); end
        checks++; if (x_rv != 3) begin failures++; $display("FAIL rd0_latency got=%0d exp=3", x_rv); end
        checks++; if (x_psel != 2 || x_acc != 1) begin failures++; $display("FAIL rd0_phases got=%0d/%0d exp=2/1", x_psel, x_acc); end
        checks++; if (!x_stable) begin failures++; $display("FAIL rd0_apb_addr got=0 exp=1"); end
        checks++; if (x_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd0_rdata got=%h exp=12345678", x_rdata); end
        checks++; if ({x_opc, x_id} !== {1'b0, 5'd3}) begin failures++; $display("FAIL rd0_opc_id got=%b/%0d exp=0/3", x_opc, x_id); end
        checks++; if (x_after !== 1'b0) begin failures++; $display("FAIL rd0_rvalid_pulse got=%b exp=0", x_after); end
    endtask

    task automatic test_write_wait3();
        xfer(32'h1A10_1008, 1'b0, 32'hCAFE_F00D, 4'hF, 5'd7, 3, 1'b0, 32'hFFFF_FFFF, 1'b0);
        checks++; if (x_rv != 6) begin failures++; $display("FAIL wr3_latency got=%0d exp=6", x_rv); end
        checks++; if (x_acc != 4) begin failures++; $display("FAIL wr3_access_cycles got=%0d exp=4", x_acc); end
        checks++; if (!x_stable) begin failures++; $display("FAIL wr3_pwdata_stable got=0 exp=1"); end
        checks++; if ({x_opc, x_rdata, x_id} !== {1'b0, 32'h0, 5'd7}) begin
            failures++; $display("FAIL wr3_resp got=%b/%h/%0d exp=0/00000000/7", x_opc, x_rdata, x_id);
        end
    endtask

    task automatic test_slave_error();
        xfer(32'h1A10_2000, 1'b1, 32'h0, 4'hF, 5'd9, 1, 1'b0, 32'h0000_0055, 1'b1);
        checks++; if (x_rv != 4) begin failures++; $display("FAIL err_latency got=%0d exp=4", x_rv); end
        checks++; if ({x_opc, x_id} !== {1'b1, 5'd9}) begin failures++; $display("FAIL err_opc_id got=%b/%0d exp=1/9", x_opc, x_id); end
    endtask

    task automatic test_partial_write();
        xfer(32'h1A10_3004, 1'b0, 32'h1111_2222, 4'h3, 5'd12, 0, 1'b0, 32'h9999_9999, 1'b0);
        checks++; if (x_gnt0 !== 1'b1) begin failures++; $display("FAIL pw_gnt got=%b exp=1", x_gnt0); end
        checks++; if (x_psel != 0) begin failures++; $display("FAIL pw_no_psel got=%0d exp=0", x_psel); end
        checks++; if (x_rv != 1) begin failures++; $display("FAIL pw_latency got=%0d exp=1", x_rv); end
        checks++; if ({x_opc, x_rdata, x_id} !== {1'b1, 32'h0, 5'd12}) begin
            failures++; $display("FAIL pw_resp got=%b/%h/%0d exp=1/00000000/12", x_opc, x_rdata, x_id);
        end
    endtask

    task automatic test_timeout();
        xfer(32'h1A10_5000, 1'b1, 32'h0, 4'hF, 5'd17, 0, 1'b1, 32'h0, 1'b0);
        checks++; if (x_acc != 5 || x_psel != 6) begin failures++; $display("FAIL to_cycles got=%0d/%0d exp=5/6", x_acc, x_psel); end
        checks++; if (x_rv != 7) begin failures++; $display("FAIL to_latency got=%0d exp=7", x_rv); end
        checks++; if ({x_opc, x_rdata, x_id} !== {1'b1, 32'hDEAD_0B0B, 5'd17}) begin
            failures++; $display("FAIL to_resp got=%b/%h/%0d exp=1/dead0b0b/17", x_opc, x_rdata, x_id);
        end
        xfer(32'h1A10_5004, 1'b1, 32'h0, 4'hF, 5'd18, 4, 1'b0, 32'hA5A5_0001, 1'b0);
        checks++; if (x_acc != 5 || x_rv != 7) begin failures++; $display("FAIL to_race_cycles got=%0d/%0d exp=5/7", x_acc, x_rv); end
        checks++; if ({x_opc, x_rdata} !== {1'b0, 32'hA5A5_0001}) begin
            failures++; $display("FAIL to_race_resp got=%b/%h exp=0/a5a50001", x_opc, x_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] gmask;
        int          nrv;
        gmask = '0;
        nrv   = 0;
        lint.data_req_i = 1'b1; lint.data_add_i = 32'h1A10_6000; lint.data_wen_i = 1'b1;
        lint.data_be_i = 4'hF; lint.data_id_i = 5'd21;
        apb.pready_i = 1'b1; apb.prdata_i = 32'h0BAD_CAFE; apb.pslverr_i = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 0) #1;
            gmask[c] = lint.data_gnt_o;
            if (lint.data_r_valid_o === 1'b1) nrv++;
            if (c == 12) lint.data_req_i = 1'b0;
            step();
        end
        apb.pready_i = 1'b0;
        checks++; if (gmask !== 13'b1_0001_0001_0001) begin failures++; $display("FAIL b2b_gnt_pattern got=%b exp=1000100010001", gmask); end
        checks++; if (nrv != 3) begin failures++; $display("FAIL b2b_rvalid_count got=%0d exp=3", nrv); end
        step();
    endtask

    task automatic test_reset_mid();
        int nrv;
        nrv = 0;
        lint.data_req_i = 1'b1; lint.data_add_i = 32'h1A10_7000; lint.data_wen_i = 1'b1;
        lint.data_be_i = 4'hF; lint.data_id_i = 5'd30;
        apb.pready_i = 1'b0; apb.prdata_i = 32'h7777_7777;
        step();
        lint.data_req_i = 1'b0;
        step();
        checks++; if ({apb.psel_o, apb.penable_o} !== 2'b11) begin failures++; $display("FAIL rst_mid_access got=%b exp=11", {apb.psel_o, apb.penable_o}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({apb.psel_o, apb.penable_o} !== 2'b00) begin failures++; $display("FAIL rst_mid_psel_drop got=%b exp=00", {apb.psel_o, apb.penable_o}); end
        step(); if (lint.data_r_valid_o === 1'b1) nrv++;
        step(); if (lint.data_r_valid_o === 1'b1) nrv++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (lint.data_r_valid_o === 1'b1) nrv++;
        end
        checks++; if (nrv != 0) begin failures++; $display("FAIL rst_mid_no_resp got=%0d exp=0", nrv); end
        xfer(32'h1A10_7004, 1'b1, 32'h0, 4'hF, 5'd5, 0, 1'b0, 32'h0102_0304, 1'b0);
        checks++; if (x_rv != 3 || {x_opc, x_rdata, x_id} !== {1'b0, 32'h0102_0304, 5'd5}) begin
            failures++; $display("FAIL rst_mid_recover got=%0d/%b/%h/%0d exp=3/0/01020304/5", x_rv, x_opc, x_rdata, x_id);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait3();
        test_slave_error();
        test_partial_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
